// File: rtl/rob_multiport_if.sv
// rtl/rob_multiport_if.sv - issue, writeback, commit, lookup and release bundle for rob_multiport
// slave is the reorder buffer side, master is the pipeline (or bench) side.
interface rob_multiport_if #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CDB_N  = 2
);
    localparam int TAG_W = $clog2(DEPTH);

    logic                     rdy_in;
    logic                     flush_in;
    logic                     issue_valid_in;
    logic                     issue_done_in;
    logic [REG_W-1:0]         issue_rd_in;
    logic [1:0]               issue_type_in;
    logic [TAG_W-1:0]         issue_tag_out;
    logic                     full_out;
    logic [TAG_W:0]           count_out;
    logic [CDB_N-1:0]         cdb_valid_in;
    logic [CDB_N*TAG_W-1:0]   cdb_tag_in;
    logic [CDB_N*DATA_W-1:0]  cdb_data_in;
    logic [CDB_N-1:0]         cdb_jump_in;
    logic [CDB_N*ADDR_W-1:0]  cdb_jaddr_in;
    logic                     commit_valid_out;
    logic                     commit_ack_in;
    logic [TAG_W-1:0]         commit_tag_out;
    logic [REG_W-1:0]         commit_rd_out;
    logic [DATA_W-1:0]        commit_data_out;
    logic                     commit_jump_out;
    logic [ADDR_W-1:0]        commit_jaddr_out;
    logic [1:0]               commit_type_out;
    logic                     qa_valid_in;
    logic [TAG_W-1:0]         qa_tag_in;
    logic                     qa_ready_out;
    logic [DATA_W-1:0]        qa_data_out;
    logic                     qb_valid_in;
    logic [TAG_W-1:0]         qb_tag_in;
    logic                     qb_ready_out;
    logic [DATA_W-1:0]        qb_data_out;
    logic                     sl_release_out;
    logic [TAG_W-1:0]         sl_release_tag_out;

    modport slave (
        input  rdy_in, flush_in,
        input  issue_valid_in, issue_done_in, issue_rd_in, issue_type_in,
        output issue_tag_out, full_out, count_out,
        input  cdb_valid_in, cdb_tag_in, cdb_data_in, cdb_jump_in, cdb_jaddr_in,
        output commit_valid_out, commit_tag_out, commit_rd_out, commit_data_out,
        output commit_jump_out, commit_jaddr_out, commit_type_out,
        input  commit_ack_in,
        input  qa_valid_in, qa_tag_in, qb_valid_in, qb_tag_in,
        output qa_ready_out, qa_data_out, qb_ready_out, qb_data_out,
        output sl_release_out, sl_release_tag_out
    );

    modport master (
        output rdy_in, flush_in,
        output issue_valid_in, issue_done_in, issue_rd_in, issue_type_in,
        input  issue_tag_out, full_out, count_out,
        output cdb_valid_in, cdb_tag_in, cdb_data_in, cdb_jump_in, cdb_jaddr_in,
        input  commit_valid_out, commit_tag_out, commit_rd_out, commit_data_out,
        input  commit_jump_out, commit_jaddr_out, commit_type_out,
        output commit_ack_in,
        output qa_valid_in, qa_tag_in, qb_valid_in, qb_tag_in,
        input  qa_ready_out, qa_data_out, qb_ready_out, qb_data_out,
        input  sl_release_out, sl_release_tag_out
    );
endinterface

// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - reorder buffer with CDB_N writeback buses, two lookup ports and an SL release walker
// Optional feature: define ROB_CDB_BYPASS_EN to let lookups see same-cycle CDB results.
module rob_multiport #(
    parameter int DEPTH       = 16,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int CDB_N       = 2,
    parameter int FULL_MARGIN = 2
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    rob_multiport_if.slave bus
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [1:0]     TYPE_JUMP = 2'd1;
    localparam logic [1:0]     TYPE_SL   = 2'd2;
    localparam logic [TAG_W:0] DEPTH_P   = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0] FULL_LVL  = (TAG_W+1)'(DEPTH - FULL_MARGIN);

    logic [TAG_W:0]      r_head;
    logic [TAG_W:0]      r_tail;
    logic [TAG_W:0]      r_rel;
    logic [DEPTH-1:0]    r_valid;
    logic [DEPTH-1:0]    r_done;
    logic [DEPTH-1:0]    r_jump;
    logic [REG_W-1:0]    r_rd    [DEPTH];
    logic [1:0]          r_type  [DEPTH];
    logic [DATA_W-1:0]   r_data  [DEPTH];
    logic [ADDR_W-1:0]   r_jaddr [DEPTH];
    logic                r_full;
    logic                r_sl_rel;
    logic [TAG_W-1:0]    r_sl_tag;

    logic [TAG_W-1:0]    w_head_idx;
    logic [TAG_W-1:0]    w_tail_idx;
    logic [TAG_W-1:0]    w_rel_idx;
    logic [TAG_W:0]      w_count;
    logic [TAG_W:0]      w_head_next;
    logic [TAG_W:0]      w_tail_next;
    logic [TAG_W:0]      w_count_next;
    logic [TAG_W:0]      w_rel_gap;
    logic [TAG_W:0]      w_rel_next;
    logic                w_issue;
    logic                w_commit_valid;
    logic                w_pop;
    logic                w_rel_behind;
    logic                w_rel_blocked;
    logic                w_rel_step;
    logic [TAG_W-1:0]    w_cdb_tag   [CDB_N];
    logic [DATA_W-1:0]   w_cdb_data  [CDB_N];
    logic [ADDR_W-1:0]   w_cdb_jaddr [CDB_N];
    logic                w_q_valid   [2];
    logic [TAG_W-1:0]    w_q_tag     [2];
    logic                w_q_ready   [2];
    logic [DATA_W-1:0]   w_q_data    [2];

    always_comb begin
        for (int b = 0; b < CDB_N; b++) begin
            w_cdb_tag[b]   = bus.cdb_tag_in[b*TAG_W +: TAG_W];
            w_cdb_data[b]  = bus.cdb_data_in[b*DATA_W +: DATA_W];
            w_cdb_jaddr[b] = bus.cdb_jaddr_in[b*ADDR_W +: ADDR_W];
        end
    end

    assign w_head_idx     = r_head[TAG_W-1:0];
    assign w_tail_idx     = r_tail[TAG_W-1:0];
    assign w_rel_idx      = r_rel[TAG_W-1:0];
    assign w_count        = r_tail - r_head;

    assign w_issue        = bus.rdy_in && !bus.flush_in && bus.issue_valid_in && (w_count != DEPTH_P);
    assign w_commit_valid = bus.rdy_in && !bus.flush_in && (w_count != '0) && r_done[w_head_idx];
    assign w_pop          = w_commit_valid && bus.commit_ack_in;
    assign w_head_next    = r_head + (TAG_W+1)'(w_pop);
    assign w_tail_next    = r_tail + (TAG_W+1)'(w_issue);
    assign w_count_next   = w_tail_next - w_head_next;

    // rel is at most one behind head_next, so a short positive gap means commit overtook it
    assign w_rel_gap      = w_head_next - r_rel;
    assign w_rel_behind   = (w_rel_gap != '0) && !w_rel_gap[TAG_W];
    assign w_rel_blocked  = (r_type[w_rel_idx] == TYPE_JUMP) && !r_done[w_rel_idx];
    assign w_rel_step     = !w_rel_behind && (r_rel != r_tail) && !w_rel_blocked;
    assign w_rel_next     = w_rel_behind ? w_head_next : r_rel + (TAG_W+1)'(w_rel_step);

    assign w_q_valid[0]   = bus.qa_valid_in;
    assign w_q_tag[0]     = bus.qa_tag_in;
    assign w_q_valid[1]   = bus.qb_valid_in;
    assign w_q_tag[1]     = bus.qb_tag_in;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_q_ready[p] = 1'b0;
            w_q_data[p]  = '0;
            if (w_q_valid[p]) begin
                if (r_done[w_q_tag[p]]) begin
                    w_q_ready[p] = 1'b1;
                    w_q_data[p]  = r_data[w_q_tag[p]];
                end
`ifdef ROB_CDB_BYPASS_EN
                for (int b = 0; b < CDB_N; b++) begin
                    if (bus.cdb_valid_in[b] && (w_cdb_tag[b] == w_q_tag[p])) begin
                        w_q_ready[p] = 1'b1;
                        w_q_data[p]  = w_cdb_data[b];
                    end
                end
`endif
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_rel    <= '0;
            r_valid  <= '0;
            r_done   <= '0;
            r_jump   <= '0;
            r_full   <= 1'b0;
            r_sl_rel <= 1'b0;
            r_sl_tag <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]    <= '0;
                r_type[i]  <= '0;
                r_data[i]  <= '0;
                r_jaddr[i] <= '0;
            end
        end else if (bus.flush_in) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_rel    <= '0;
            r_valid  <= '0;
            r_done   <= '0;
            r_full   <= 1'b0;
            r_sl_rel <= 1'b0;
        end else if (!bus.rdy_in) begin
            r_sl_rel <= 1'b0;
        end else begin
            r_head   <= w_head_next;
            r_tail   <= w_tail_next;
            r_rel    <= w_rel_next;
            r_full   <= (w_count_next >= FULL_LVL);
            r_sl_rel <= w_rel_step && (r_type[w_rel_idx] == TYPE_SL);
            if (w_rel_step) begin
                r_sl_tag <= w_rel_idx;
            end
            if (w_issue) begin
                r_valid[w_tail_idx] <= 1'b1;
                r_done[w_tail_idx]  <= bus.issue_done_in;
                r_rd[w_tail_idx]    <= bus.issue_rd_in;
                r_type[w_tail_idx]  <= bus.issue_type_in;
                r_data[w_tail_idx]  <= '0;
                r_jump[w_tail_idx]  <= 1'b0;
                r_jaddr[w_tail_idx] <= '0;
            end
            // later buses overwrite earlier ones, and all of them override the allocation defaults
            for (int b = 0; b < CDB_N; b++) begin
                if (bus.cdb_valid_in[b] &&
                    (r_valid[w_cdb_tag[b]] || (w_issue && (w_cdb_tag[b] == w_tail_idx)))) begin
                    r_done[w_cdb_tag[b]]  <= 1'b1;
                    r_data[w_cdb_tag[b]]  <= w_cdb_data[b];
                    r_jump[w_cdb_tag[b]]  <= bus.cdb_jump_in[b];
                    r_jaddr[w_cdb_tag[b]] <= w_cdb_jaddr[b];
                end
            end
            if (w_pop) begin
                r_valid[w_head_idx] <= 1'b0;
            end
        end
    end

    assign bus.issue_tag_out      = w_tail_idx;
    assign bus.full_out           = r_full;
    assign bus.count_out          = w_count;
    assign bus.commit_valid_out   = w_commit_valid;
    assign bus.commit_tag_out     = w_head_idx;
    assign bus.commit_rd_out      = r_rd[w_head_idx];
    assign bus.commit_data_out    = r_data[w_head_idx];
    assign bus.commit_jump_out    = r_jump[w_head_idx];
    assign bus.commit_jaddr_out   = r_jaddr[w_head_idx];
    assign bus.commit_type_out    = r_type[w_head_idx];
    assign bus.qa_ready_out       = w_q_ready[0];
    assign bus.qa_data_out        = w_q_data[0];
    assign bus.qb_ready_out       = w_q_ready[1];
    assign bus.qb_data_out        = w_q_data[1];
    assign bus.sl_release_out     = r_sl_rel && !bus.flush_in;
    assign bus.sl_release_tag_out = r_sl_tag;
endmodule

// File: doc/rob_multiport.md
# rob_multiport

Parametrised reorder buffer. It sits between issue, the reservation stations / load-store buffer, and the commit stage. Entries are allocated in program order, completed by any of `CDB_N` writeback buses, and retired in order from the head. The block also provides two operand-lookup ports for issue and a store/load release walker that runs ahead of commit and stops at unresolved jumps.

## Interface
- `DEPTH`, 16, entry count, power of 2, ≥4; `TAG_W = log2(DEPTH)` is derived.
- `DATA_W`, 32, result width.
- `ADDR_W`, 32, jump-target width.
- `REG_W`, 5, destination register index width.
- `CDB_N`, 2, number of writeback buses.
- `FULL_MARGIN`, 2, slack reserved before `full_out` asserts.

Ports:
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_n_in`  in  1  reset, asynchronous, active-low.
- `rdy_in`  in  1  global enable; low freezes all state.
- `flush_in`  in  1  synchronous flush (mispredict).
- `issue_valid_in`  in  1  allocate one entry at tail.
- `issue_done_in`  in  1  the entry is complete at allocation.
- `issue_rd_in`  in  REG_W  destination register.
- `issue_type_in`  in  2  entry type: 0 = ALU, 1 = JUMP, 2 = SL.
- `issue_tag_out`  out  TAG_W  tag of the next allocation, equal to tail mod DEPTH (combinational).
- `full_out`  out  1  registered almost-full flag.
- `count_out`  out  TAG_W+1  registered occupancy.
- `cdb_valid_in`  in  CDB_N  per-bus writeback strobe.
- `cdb_tag_in`  in  CDB_N·TAG_W  per-bus tag.
- `cdb_data_in`  in  CDB_N·DATA_W  per-bus result.
- `cdb_jump_in`  in  CDB_N  per-bus taken/redirect flag.
- `cdb_jaddr_in`  in  CDB_N·ADDR_W  per-bus jump target.
- `commit_valid_out`  out  1  the head entry is valid and complete.
- `commit_ack_in`  in  1  pop the head; honoured only while `commit_valid_out` is high.
- `commit_tag_out`, `commit_rd_out`, `commit_data_out`, `commit_jump_out`, `commit_jaddr_out`, `commit_type_out`  out  head-entry fields.
- `qa_valid_in` / `qb_valid_in`  in  1  lookup enable.
- `qa_tag_in` / `qb_tag_in`  in  TAG_W  lookup tag.
- `qa_ready_out` / `qb_ready_out`  out  1  the looked-up value is available.
- `qa_data_out` / `qb_data_out`  out  DATA_W  the looked-up value, 0 when not ready.
- `sl_release_out`  out  1  registered one-cycle pulse: an SL entry is now non-speculative.
- `sl_release_tag_out`  out  TAG_W  tag of the released SL entry.

## Operation
- State:
  - `head` and `tail` are TAG_W+1 bits wide, including a wrap bit; `count = tail − head`.
  - `rel` is the release pointer.
  - Per-entry state: `valid`, `done`, `rd`, `type`, `data`, `jump`, `jaddr`.
- Issue:
  - When `issue_valid_in` is high and `count < DEPTH`, write the entry at `tail`, set `valid` and set `done = issue_done_in`, then increment `tail`.
  - When `count == DEPTH`, the issue is dropped; the bench flags this as an error.
- CDB:
  - Each bus whose strobe is high writes `data`, `jump` and `jaddr` and sets `done`, but only if the target entry is `valid`.
  - When several buses carry the same tag, the highest bus index wins.
  - A CDB write to the entry being allocated in the same cycle takes precedence over `issue_done_in`.
- Commit:
  - `commit_valid_out = rdy_in && count != 0 && done[head]`; the commit fields show the head entry combinationally.
  - When `commit_ack_in` is high, clear `valid[head]` and increment `head`.
  - Issue and commit in the same cycle leave the count unchanged.
- `full_out` is registered as `count_next ≥ DEPTH − FULL_MARGIN`.
- Release walker, at most one step per cycle:
  - If `rel` is behind `head_next`, set `rel` to `head_next` and do not pulse.
  - Otherwise, if `rel != tail`, step forward unless `rel` points to a JUMP entry that is not yet done.
  - When the walker steps past an SL entry, `sl_release_out` pulses with that entry's tag on the next cycle.
  - `rel` never passes `tail`.
- Lookups are combinational, checked in this order:
  - `q*_valid_in` low gives ready 0 and data 0.
  - A CDB bypass (see Configuration) is checked next.
  - Otherwise the stored `done` and `data` are returned.
- Flush:
  - Sets `head = tail = rel = 0`, clears every `valid` and `done`, and forces `commit_valid_out` and `sl_release_out` to 0.
  - Flush has priority over issue, CDB and ack, and takes effect even when `rdy_in` is low.

## Timing
- Reset values: `full_out` = 0, `count_out` = 0, `sl_release_out` = 0, `sl_release_tag_out` = 0, `issue_tag_out` = 0, `commit_valid_out` = 0. All pointers and `valid`/`done` bits are cleared.
- CDB write at edge t: `commit_valid_out` can rise in cycle t+1, and stored lookups see the value from t+1.
- Issue at edge t: `count_out` and `full_out` reflect it from t+1.
- Wrap-around: pointer index = pointer mod DEPTH. Full versus empty is distinguished by the wrap bit.
- `rdy_in` low: no state changes, `commit_valid_out` is 0, and `commit_ack_in` is ignored.

## Configuration
- `ROB_CDB_BYPASS_EN`
  - Defined: lookups also match the same-cycle CDB strobes (highest matching bus index) ahead of stored state, returning ready 1 and the bus data in the same cycle.
  - Undefined: lookups use stored state only, so a value arriving on the CDB becomes visible one cycle later.

## Test plan
- Reset, then issue 16 ALU entries with `DEPTH` = 16 and `FULL_MARGIN` = 2 -> `full_out` rises after the 14th issue, `count_out` reaches 16, and a 17th issue is dropped.
- Issue tags 0–2; CDB0 completes tag 1 with 0x11 and CDB1 completes tag 0 with 0x22 in the same cycle; ack every time valid is high -> commits occur in order: 0x22 at tag 0, then 0x11 at tag 1.
- Both buses write tag 3 in the same cycle (0xAA on bus 0, 0xBB on bus 1) -> committed data is 0xBB.
- Issue SL, JUMP (not done), SL -> one release pulse for tag 0; the walker stalls at tag 1; after CDB completes tag 1, a pulse follows for tag 2.
- With `ROB_CDB_BYPASS_EN`, look up tag 5 while CDB0 carries tag 5 with 0x55 -> `qa_ready_out` = 1 and data = 0x55 in the same cycle. Without the macro, ready = 0 that cycle and ready = 1 with 0x55 in the next cycle.
- Fill 10 entries, ack 4, then flush while `rdy_in` is low -> `count_out` = 0 and `commit_valid_out` = 0; the next issue receives tag 0.
